// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   pll_state_e : supervisor FSM states
//   ctr_width() : counter width able to hold 0..max (never narrower than 1 bit)
package pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } pll_state_e;

  function automatic int ctr_width(input int max);
    int w;
    w = $clog2(max + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lock_filter.sv
// Synchroniser and debounce filter for one PLL LOCK input.
// Ports:
//   clock    in  reference clock
//   reset    in  synchronous active-high reset
//   clear_i  in  holds the debounce counter at zero (PLL under reset)
//   lock_i   in  raw LOCK, asynchronous to clock
//   synced_o out LOCK after the 2-FF synchroniser (unfiltered)
//   locked_o out registered filtered lock: synced high for LOCK_FILTER cycles
module lock_filter
  import pll_pkg::*;
#(
  parameter int LOCK_FILTER = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic lock_i,
  output logic synced_o,
  output logic locked_o
);

  localparam int CW = ctr_width(LOCK_FILTER);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          locked_q;

  // Any synced low restarts the debounce; the counter parks at LOCK_FILTER.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LOCK_FILTER)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      sync1_q  <= lock_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      locked_q <= (cnt_d == CW'(LOCK_FILTER));
    end
  end

  assign synced_o = sync2_q;
  assign locked_o = locked_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervisor for NUM_PLLS PLL wrappers: filters each LOCK, drives a shared PLL
// reset, retries on timeout or lock loss, and releases sys_rst only after all
// PLLs have been stably locked for RESET_DELAY cycles.
// Ports:
//   clock        in  free-running reference clock
//   reset        in  synchronous active-high reset
//   lock_in      in  raw PLL LOCK signals (asynchronous)
//   retry_req    in  one-cycle pulse, restarts the sequence from FAILED
//   pll_rst      out shared PLL reset, active high
//   sys_rst      out system reset, active high
//   ready        out high in RUN
//   fail         out high in FAILED
//   locked_mask  out per-PLL filtered lock
//   retry_count  out failed attempts in the current bring-up
//   loss_count   out saturating count of lock losses seen in RUN
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int NUM_PLLS     = 1,
  parameter int RST_HOLD     = 8,
  parameter int LOCK_FILTER  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RESET_DELAY  = 32,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PLLS-1:0]                 lock_in,
  input  logic                                retry_req,
  output logic                                pll_rst,
  output logic                                sys_rst,
  output logic                                ready,
  output logic                                fail,
  output logic [NUM_PLLS-1:0]                 locked_mask,
  output logic [ctr_width(MAX_RETRIES)-1:0]   retry_count,
  output logic [7:0]                          loss_count
);

  localparam int RC_W    = ctr_width(MAX_RETRIES);
  // One timer serves all timed states; it is cleared on every state change.
  localparam int TMR_MAX = (RST_HOLD > LOCK_TIMEOUT)
                         ? ((RST_HOLD > RESET_DELAY) ? RST_HOLD : RESET_DELAY)
                         : ((LOCK_TIMEOUT > RESET_DELAY) ? LOCK_TIMEOUT : RESET_DELAY);
  localparam int TMR_W   = ctr_width(TMR_MAX);

  pll_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, sys_rst_q, ready_q, fail_q;
  logic             attempt_failed;

  logic [NUM_PLLS-1:0] synced;
  logic [NUM_PLLS-1:0] locked;

  generate
    for (genvar gi = 0; gi < NUM_PLLS; gi++) begin : g_filter
      lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
      ) u_lock_filter (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (pll_rst_q),
        .lock_i   (lock_in[gi]),
        .synced_o (synced[gi]),
        .locked_o (locked[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    retry_d        = retry_q;
    loss_d         = loss_q;
    attempt_failed = 1'b0;

    case (state_q)
      RESET_PLL: begin
        if (timer_q == TMR_W'(RST_HOLD - 1)) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_LOCK: begin
        // Completing lock wins over a timeout in the same cycle.
        if (&locked) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          attempt_failed = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      STABLE: begin
        if (!(&locked)) begin
          attempt_failed = 1'b1;
        end else if (timer_q == TMR_W'(RESET_DELAY - 1)) begin
          state_d = RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RUN: begin
        // Loss is detected on the synced bit, bypassing the debounce.
        if (!(&synced)) begin
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          retry_d = '0;
          state_d = RESET_PLL;
          timer_d = '0;
        end
      end
      FAILED: begin
        if (retry_req) begin
          retry_d = '0;
          state_d = RESET_PLL;
          timer_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        timer_d = '0;
      end
    endcase

    if (attempt_failed) begin
      timer_d = '0;
      if (retry_q < RC_W'(MAX_RETRIES)) begin
        retry_d = retry_q + RC_W'(1);
        state_d = RESET_PLL;
      end else begin
        state_d = FAILED;
      end
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RESET_PLL;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == RESET_PLL);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
      fail_q    <= (state_d == FAILED);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign locked_mask = locked;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with NUM_PLLS=2, RST_HOLD=4,
// LOCK_FILTER=3, LOCK_TIMEOUT=20, RESET_DELAY=5, MAX_RETRIES=2.
// Inputs change and outputs are sampled on the falling clock edge; k counts
// rising edges since the start of each step.
module tb_pll_lock_supervisor;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] lock_in;
  logic       retry_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] locked_mask;
  logic [1:0] retry_count;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pll_lock_supervisor #(
    .NUM_PLLS    (2),
    .RST_HOLD    (4),
    .LOCK_FILTER (3),
    .LOCK_TIMEOUT(20),
    .RESET_DELAY (5),
    .MAX_RETRIES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .lock_in     (lock_in),
    .retry_req   (retry_req),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fail        (fail),
    .locked_mask (locked_mask),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    check({tag, "_ready"},   32'(ready),   32'd0);
    check({tag, "_fail"},    32'(fail),    32'd0);
    check({tag, "_locked"},  32'(locked_mask), 32'd0);
    check({tag, "_retry"},   32'(retry_count), 32'd0);
    check({tag, "_loss"},    32'(loss_count),  32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    lock_in   = 2'b11;
    retry_req = 1'b0;
    repeat (3) tick();

    // ---- 1: bring-up with both locks held high ----
    check_reset_state("t1_rst");
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k <= 4) check($sformatf("t1_pll_rst_k%0d", k), 32'(pll_rst), (k < 4) ? 32'd1 : 32'd0);
      if (k == 6) check("t1_locked_k6", 32'(locked_mask), 32'd0);
      if (k == 7) check("t1_locked_k7", 32'(locked_mask), 32'd3);
      if (k == 12) check("t1_sys_rst_k12", 32'(sys_rst), 32'd1);
      if (k == 13) begin
        check("t1_sys_rst_k13", 32'(sys_rst), 32'd0);
        check("t1_ready_k13",   32'(ready),   32'd1);
      end
    end
    $display("step 1 bring-up: ready=%0d sys_rst=%0d", ready, sys_rst);

    // retry_req has no effect outside FAILED
    retry_req = 1'b1;
    tick();
    retry_req = 1'b0;
    check("rq_ign_ready",   32'(ready),   32'd1);
    check("rq_ign_pll_rst", 32'(pll_rst), 32'd0);
    $display("retry_req in RUN: ready=%0d pll_rst=%0d", ready, pll_rst);

    // ---- 4: one-cycle glitch on lock_in[0] while in RUN ----
    lock_in = 2'b10;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) lock_in = 2'b11;
      if (k == 2) begin
        check("t4_ready_k2",   32'(ready),   32'd1);
        check("t4_sys_rst_k2", 32'(sys_rst), 32'd0);
      end
      if (k == 3) begin
        check("t4_ready_k3",   32'(ready),      32'd0);
        check("t4_sys_rst_k3", 32'(sys_rst),    32'd1);
        check("t4_pll_rst_k3", 32'(pll_rst),    32'd1);
        check("t4_loss_k3",    32'(loss_count), 32'd1);
      end
      if (k == 15) check("t4_ready_k15", 32'(ready), 32'd0);
      if (k == 16) check("t4_ready_k16", 32'(ready), 32'd1);
    end
    $display("step 4 glitch: loss_count=%0d ready=%0d", loss_count, ready);

    // ---- 2: lock_in[1] stuck low -> retries then FAILED ----
    lock_in = 2'b01;
    for (int k = 1; k <= 78; k++) begin
      tick();
      if (k == 3)  check("t2_loss_k3",   32'(loss_count),  32'd2);
      if (k == 26) begin
        check("t2_retry_k26",   32'(retry_count), 32'd0);
        check("t2_pll_rst_k26", 32'(pll_rst),     32'd0);
      end
      if (k == 27) begin
        check("t2_retry_k27",   32'(retry_count), 32'd1);
        check("t2_pll_rst_k27", 32'(pll_rst),     32'd1);
      end
      if (k == 50) check("t2_retry_k50", 32'(retry_count), 32'd1);
      if (k == 51) check("t2_retry_k51", 32'(retry_count), 32'd2);
      if (k == 74) begin
        check("t2_fail_k74",   32'(fail),        32'd0);
        check("t2_locked_k74", 32'(locked_mask), 32'd1);
      end
      if (k == 75 || k == 78) begin
        check($sformatf("t2_fail_k%0d", k),    32'(fail),        32'd1);
        check($sformatf("t2_pll_rst_k%0d", k), 32'(pll_rst),     32'd0);
        check($sformatf("t2_sys_rst_k%0d", k), 32'(sys_rst),     32'd1);
        check($sformatf("t2_ready_k%0d", k),   32'(ready),       32'd0);
        check($sformatf("t2_retry_k%0d", k),   32'(retry_count), 32'd2);
      end
    end
    $display("step 2 stuck lock: fail=%0d retry_count=%0d", fail, retry_count);

    // ---- 3: recover from FAILED with retry_req ----
    retry_req = 1'b1;
    lock_in   = 2'b11;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) begin
        retry_req = 1'b0;
        check("t3_retry_k1",   32'(retry_count), 32'd0);
        check("t3_fail_k1",    32'(fail),        32'd0);
        check("t3_pll_rst_k1", 32'(pll_rst),     32'd1);
      end
      if (k == 13) check("t3_ready_k13", 32'(ready), 32'd0);
      if (k == 14) begin
        check("t3_ready_k14",   32'(ready),   32'd1);
        check("t3_sys_rst_k14", 32'(sys_rst), 32'd0);
      end
    end
    $display("step 3 retry: ready=%0d retry_count=%0d", ready, retry_count);

    // ---- 5: lock_in[0] toggling every 2 cycles never passes the filter ----
    lock_in = 2'b10;
    for (int k = 1; k <= 27; k++) begin
      tick();
      if (k == 3) begin
        check("t5_loss_k3",    32'(loss_count), 32'd3);
        check("t5_pll_rst_k3", 32'(pll_rst),    32'd1);
      end
      if (k >= 3) check($sformatf("t5_locked0_k%0d", k), 32'(locked_mask[0]), 32'd0);
      if (k == 7)  check("t5_pll_rst_k7", 32'(pll_rst),     32'd0);
      if (k == 10) check("t5_locked_k10", 32'(locked_mask), 32'd2);
      if (k == 26) check("t5_retry_k26",  32'(retry_count), 32'd0);
      if (k == 27) begin
        check("t5_retry_k27",   32'(retry_count), 32'd1);
        check("t5_pll_rst_k27", 32'(pll_rst),     32'd1);
      end
      if (k % 2 == 0) lock_in[0] = ~lock_in[0];
    end
    $display("step 5 toggling: retry_count=%0d locked_mask=%b", retry_count, locked_mask);

    // ---- 6: reset asserted while in STABLE ----
    lock_in = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) check("t6_pll_rst_k4", 32'(pll_rst),     32'd0);
      if (k == 7) check("t6_locked_k7",  32'(locked_mask), 32'd3);
      if (k == 9) begin
        check("t6_sys_rst_k9", 32'(sys_rst),     32'd1);
        check("t6_ready_k9",   32'(ready),       32'd0);
        check("t6_retry_k9",   32'(retry_count), 32'd1);
        check("t6_loss_k9",    32'(loss_count),  32'd3);
      end
    end
    reset = 1'b1;
    tick();
    check_reset_state("t6_rst");
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 12) check("t6_ready_k12", 32'(ready), 32'd0);
      if (k == 13) begin
        check("t6_ready_k13", 32'(ready),      32'd1);
        check("t6_loss_k13",  32'(loss_count), 32'd0);
      end
    end
    $display("step 6 reset in STABLE: ready=%0d loss_count=%0d", ready, loss_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
